fft_butterfly_scheduler: RTL and testbench

//  Sequences an in-place radix-2 DIT FFT over one sample RAM and one butterfly_sum datapath.

---
 rtl/fft_butterfly_scheduler_pkg.sv | 14 +
 rtl/fft_butterfly_scheduler_if.sv | 33 +++
 rtl/fft_butterfly_scheduler_addr_gen.sv | 33 +++
 rtl/fft_butterfly_scheduler.sv | 102 ++++++++++
 tb/tb_fft_butterfly_scheduler.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_butterfly_scheduler_pkg.sv
// fft_butterfly_scheduler_pkg: shared constants and state encoding for the FFT butterfly scheduler
// Contents:
//   LOG2N_DEF / N_DEF           default transform size (N = 8)
//   MEM_LAT_DEF / BF_LAT_DEF    default RAM read and butterfly latencies
//   BF_TOTAL_LAT                read-to-write-back distance for the defaults
//   state_t                     scheduler FSM states
package fft_butterfly_scheduler_pkg;
    localparam int LOG2N_DEF    = 3;
    localparam int N_DEF        = 1 << LOG2N_DEF;
    localparam int MEM_LAT_DEF  = 1;
    localparam int BF_LAT_DEF   = 1;
    localparam int BF_TOTAL_LAT = MEM_LAT_DEF + BF_LAT_DEF;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
endpackage

// File: rtl/fft_butterfly_scheduler_if.sv
// fft_butterfly_scheduler_if: control, RAM strobe and address bundle around the FFT scheduler
// Signals:
//   i_start              one-FFT request from the top-level control
//   o_busy / o_done      run status and one-cycle completion pulse
//   o_rd_en / o_wr_en    sample-RAM read and write strobes (both ports)
//   o_addr_a / o_addr_b  operand A/B addresses, shared by read and write-back
//   o_tw_idx             twiddle ROM index
//   o_stage              current stage number
// Modports: master = scheduler side, slave = control/RAM side.
interface fft_butterfly_scheduler_if
    import fft_butterfly_scheduler_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
);
    localparam int SW = $clog2(LOG2N);
    logic             i_start;
    logic             o_busy;
    logic             o_done;
    logic             o_rd_en;
    logic             o_wr_en;
    logic [LOG2N-1:0] o_addr_a;
    logic [LOG2N-1:0] o_addr_b;
    logic [LOG2N-2:0] o_tw_idx;
    logic [SW-1:0]    o_stage;
    modport master (
        input  i_start,
        output o_busy, o_done, o_rd_en, o_wr_en, o_addr_a, o_addr_b, o_tw_idx, o_stage
    );
    modport slave (
        output i_start,
        input  o_busy, o_done, o_rd_en, o_wr_en, o_addr_a, o_addr_b, o_tw_idx, o_stage
    );
endinterface

// File: rtl/fft_butterfly_scheduler_addr_gen.sv
// fft_butterfly_scheduler_addr_gen: maps (stage, butterfly) to operand addresses and twiddle index
// Ports:
//   stage   in   current stage s
//   k       in   butterfly index within the stage, 0..N/2-1
//   addr_a  out  address of operand A
//   addr_b  out  address of operand B (addr_a + 2^s)
//   tw_idx  out  twiddle ROM index
module fft_butterfly_scheduler_addr_gen
    import fft_butterfly_scheduler_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [$clog2(LOG2N)-1:0] stage,
    input  logic [LOG2N-2:0]         k,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx
);
    localparam int SW = $clog2(LOG2N);
    logic [LOG2N-1:0] kk;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    assign kk     = {1'b0, k};
    assign span   = LOG2N'(1) << stage;
    assign pos    = kk & (span - 1'b1);
    assign grp    = kk >> stage;
    // Two-step shift keeps the amount within SW bits when s = LOG2N-1.
    assign addr_a = ((grp << stage) << 1) | pos;
    assign addr_b = addr_a + span;
    // pos < 2^s, so shifting by LOG2N-1-s always stays below N/2.
    assign tw_idx = (LOG2N-1)'(pos << (SW'(LOG2N - 1) - stage));
endmodule

// File: rtl/fft_butterfly_scheduler.sv
// fft_butterfly_scheduler: sequences an in-place radix-2 DIT FFT over one sample RAM and one butterfly
// Ports:
//   i_CLK    rising-edge clock
//   i_RESET  asynchronous active-high reset
//   bus      master side of fft_butterfly_scheduler_if: i_start in; o_busy, o_done,
//            o_rd_en, o_wr_en, o_addr_a, o_addr_b, o_tw_idx, o_stage out
module fft_butterfly_scheduler
    import fft_butterfly_scheduler_pkg::*;
#(
    parameter int LOG2N   = LOG2N_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int BF_LAT  = BF_LAT_DEF
) (
    input  logic i_CLK,
    input  logic i_RESET,
    fft_butterfly_scheduler_if.master bus
);
    localparam int SW       = $clog2(LOG2N);
    localparam int TOT_LAT  = MEM_LAT + BF_LAT;
    localparam int WAIT_CYC = TOT_LAT - 1;
    localparam int CW       = $clog2(TOT_LAT + 1);
    state_t           state;
    state_t           state_nxt;
    logic [LOG2N-2:0] k;
    logic [LOG2N-2:0] k_nxt;
    logic [SW-1:0]    stage;
    logic [SW-1:0]    stage_nxt;
    logic [CW-1:0]    cnt;
    logic             last_k;
    logic             last_bf;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw;

    assign last_k  = &k;
    assign last_bf = last_k && (stage == SW'(LOG2N - 1));
    // Counters advance only as a WRITE retires; the final wrap clears stage
    // so the next run starts from stage 0 without an extra clear path.
    assign k_nxt     = (state == WRITE) ? k + 1'b1 : k;
    assign stage_nxt = (state == WRITE && last_k) ? (last_bf ? '0 : stage + 1'b1) : stage;

    // Addresses are generated from the upcoming (stage, k) so they can be
    // registered on the edge that enters ISSUE and held through WRITE.
    fft_butterfly_scheduler_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .stage  (stage_nxt),
        .k      (k_nxt),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.i_start ? ISSUE : IDLE;
            ISSUE:   state_nxt = (WAIT_CYC == 0) ? WRITE : WAIT;
            WAIT:    state_nxt = (cnt == CW'(WAIT_CYC - 1)) ? WRITE : WAIT;
            WRITE:   state_nxt = last_bf ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            k      <= '0;
            stage  <= '0;
            cnt    <= '0;
            addr_a <= '0;
            addr_b <= '0;
            tw     <= '0;
        end else begin
            k     <= k_nxt;
            stage <= stage_nxt;
            cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (state_nxt == ISSUE) begin
                addr_a <= gen_a;
                addr_b <= gen_b;
                tw     <= gen_tw;
            end
        end
    end

    assign bus.o_busy   = (state == ISSUE) || (state == WAIT) || (state == WRITE);
    assign bus.o_done   = (state == DONE);
    assign bus.o_rd_en  = (state == ISSUE);
    assign bus.o_wr_en  = (state == WRITE);
    assign bus.o_addr_a = addr_a;
    assign bus.o_addr_b = addr_b;
    assign bus.o_tw_idx = tw;
    assign bus.o_stage  = stage;
endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// tb_fft_butterfly_scheduler: self-checking bench for the FFT butterfly scheduler
module tb_fft_butterfly_scheduler;
    typedef struct {int st; int k; int a; int b; int tw;} vec_t;
    typedef struct {int t; int a; int b;} wexp_t;

    logic clk = 0;
    logic rst = 1;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[12];
    vec_t exp_q[$];
    wexp_t wq[$];

    always #5 clk = ~clk;

    fft_butterfly_scheduler_if #(.LOG2N(3)) if0 ();
    fft_butterfly_scheduler_if #(.LOG2N(3)) if1 ();

    fft_butterfly_scheduler #(.LOG2N(3), .MEM_LAT(1), .BF_LAT(1)) u_dut0 (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (if0)
    );
    fft_butterfly_scheduler #(.LOG2N(3), .MEM_LAT(2), .BF_LAT(2)) u_dut1 (
        .i_CLK   (clk),
        .i_RESET (rst),
        .bus     (if1)
    );

    logic       sel = 0;
    logic       rd_m, wr_m, busy_m, done_m;
    logic [2:0] a_m, b_m;
    logic [1:0] tw_m, st_m;
    always_comb begin
        rd_m   = sel ? if1.o_rd_en  : if0.o_rd_en;
        wr_m   = sel ? if1.o_wr_en  : if0.o_wr_en;
        busy_m = sel ? if1.o_busy   : if0.o_busy;
        done_m = sel ? if1.o_done   : if0.o_done;
        a_m    = sel ? if1.o_addr_a : if0.o_addr_a;
        b_m    = sel ? if1.o_addr_b : if0.o_addr_b;
        tw_m   = sel ? if1.o_tw_idx : if0.o_tw_idx;
        st_m   = sel ? if1.o_stage  : if0.o_stage;
    end

    // Sample RAM plus a one-register butterfly behind the default-latency DUT.
    // The write only carries a real result if wr_en lands exactly two cycles
    // after rd_en; any other timing is counted in bad_wr.
    int   ram[8];
    int   ds0, dd0, ds1, dd1;
    logic dv0 = 0, dv1 = 0;
    int   bad_wr = 0;
    logic ram_ld = 0;
    always @(posedge clk) begin
        if (ram_ld)
            for (int i = 0; i < 8; i++) ram[i] <= (i == 0) ? 1 : 0;
        dv0 <= if0.o_rd_en;
        // Impulse input keeps every B operand at zero, so the twiddle product drops out.
        ds0 <= ram[if0.o_addr_a] + ram[if0.o_addr_b];
        dd0 <= ram[if0.o_addr_a] - ram[if0.o_addr_b];
        dv1 <= dv0;
        ds1 <= ds0;
        dd1 <= dd0;
        if (if0.o_wr_en) begin
            if (!dv1) bad_wr <= bad_wr + 1;
            ram[if0.o_addr_a] <= ds1;
            ram[if0.o_addr_b] <= dd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One full FFT on the selected DUT; lat = MEM_LAT + BF_LAT of that DUT.
    task automatic run(input bit s, input int lat, input bit hold, output int done_at);
        int    busy = 0;
        int    nwr = 0;
        int    ca = 0, cb = 0;
        vec_t  v;
        wexp_t w;
        sel = s;
        done_at = -1;
        exp_q.delete();
        wq.delete();
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        @(negedge clk);
        if (s) if1.i_start = 1; else if0.i_start = 1;
        for (int c = 1; c <= 400 && done_at < 0; c++) begin
            @(negedge clk);
            if (!hold) begin
                if0.i_start = 0;
                if1.i_start = 0;
            end
            busy += int'(busy_m);
            if (rd_m && wr_m) chk("rd_wr_overlap", 1, 0);
            if (rd_m) begin
                if (exp_q.size() == 0) chk("extra_rd", 1, 0);
                else begin
                    v = exp_q.pop_front();
                    chk($sformatf("rd_pair_s%0d_k%0d", v.st, v.k), {22'd0, st_m, tw_m, a_m, b_m},
                        {22'd0, 2'(v.st), 2'(v.tw), 3'(v.a), 3'(v.b)});
                    ca = v.a;
                    cb = v.b;
                    wq.push_back('{c + lat, v.a, v.b});
                end
            end else if (busy_m)
                chk("addr_hold", {26'd0, a_m, b_m}, {26'd0, 3'(ca), 3'(cb)});
            if (wr_m) begin
                if (wq.size() == 0) chk("extra_wr", 1, 0);
                else begin
                    w = wq.pop_front();
                    nwr++;
                    chk("wr_time", c, w.t);
                    chk("wr_addr", {26'd0, a_m, b_m}, {26'd0, 3'(w.a), 3'(w.b)});
                end
            end
            if (done_m) begin
                chk("done_not_busy", {31'd0, busy_m}, 0);
                done_at = c;
            end
        end
        if (done_at < 0) chk("done_timeout", 1, 0);
        chk("busy_cycles", busy, 12 * (lat + 1));
        chk("done_cycle", done_at, 12 * (lat + 1) + 1);
        chk("rd_count_left", exp_q.size(), 0);
        chk("wr_count", nwr, 12);
    endtask

    initial begin
        int d;
        int g;
        logic acc;
        tbl = '{'{0, 0, 0, 1, 0}, '{0, 1, 2, 3, 0}, '{0, 2, 4, 5, 0}, '{0, 3, 6, 7, 0},
                '{1, 0, 0, 2, 0}, '{1, 1, 1, 3, 2}, '{1, 2, 4, 6, 0}, '{1, 3, 5, 7, 2},
                '{2, 0, 0, 4, 0}, '{2, 1, 1, 5, 1}, '{2, 2, 2, 6, 2}, '{2, 3, 3, 7, 3}};
        if0.i_start = 0;
        if1.i_start = 0;
        #3;
        chk("reset_outputs_dut0", {18'd0, if0.o_rd_en, if0.o_wr_en, if0.o_busy, if0.o_done,
            if0.o_addr_a, if0.o_addr_b, if0.o_tw_idx, if0.o_stage}, 0);
        chk("reset_outputs_dut1", {18'd0, if1.o_rd_en, if1.o_wr_en, if1.o_busy, if1.o_done,
            if1.o_addr_a, if1.o_addr_b, if1.o_tw_idx, if1.o_stage}, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Single pulse, default latencies: 3 cycles per butterfly.
        run(0, 2, 0, d);
        // Longer latencies: 5 cycles per butterfly.
        repeat (2) @(negedge clk);
        run(1, 4, 0, d);

        // Start held high: no restart until DONE -> IDLE, then rd one cycle later.
        repeat (2) @(negedge clk);
        run(0, 2, 1, d);
        @(negedge clk);
        chk("idle_after_done", {30'd0, busy_m, rd_m}, 0);
        @(negedge clk);
        chk("restart_rd", {31'd0, rd_m}, 1);
        chk("restart_pair", {26'd0, a_m, b_m}, {26'd0, 3'd0, 3'd1});
        if0.i_start = 0;

        // Asynchronous reset mid-stage 1.
        g = 0;
        while (st_m != 2'd1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("reach_stage1", {30'd0, st_m}, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async_reset_outputs", {18'd0, if0.o_rd_en, if0.o_wr_en, if0.o_busy, if0.o_done,
            if0.o_addr_a, if0.o_addr_b, if0.o_tw_idx, if0.o_stage}, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        acc = 0;
        repeat (8) begin
            @(negedge clk);
            acc = acc | done_m | busy_m | rd_m;
        end
        chk("quiet_after_abort", {31'd0, acc}, 0);

        // Fresh start after abort, end-to-end through the RAM model.
        @(negedge clk);
        ram_ld = 1;
        @(negedge clk);
        ram_ld = 0;
        run(0, 2, 0, d);
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk($sformatf("ram_word%0d", i), ram[i], 1);
        chk("bf_result_timing", bad_wr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
